// File: rtl/clk_ctrl_pkg.sv
// Shared defaults and interrupt-state encoding for clk_ctrl_gen.
package clk_ctrl_pkg;

    localparam int unsigned CNT_W_DEF    = 32;
    localparam int unsigned FAST_TAP_DEF = 3;
    localparam int unsigned SLOW_TAP_DEF = 24;
    localparam int unsigned INT_W_DEF    = 32;
    localparam int unsigned DB_TAP_DEF   = 16;

    typedef logic [1:0] int_state_t;

    localparam int_state_t IDLE    = 2'd0;
    localparam int_state_t PENDING = 2'd1;
    localparam int_state_t OVERRUN = 2'd2;

endpackage

// File: rtl/clk_tap_switch.sv
// Synchronised two-input clock selector: the active input only changes while
// both the output and the newly requested input are low, so no runt pulse appears.
module clk_tap_switch (
    input  logic clk,
    input  logic rst,
    input  logic sel_async,
    input  logic tap0,
    input  logic tap1,
    output logic clk_next,
    output logic clk_out,
    output logic tick
);

    logic [1:0] sel_sync;
    logic       sel_s;
    logic       sel_q;
    logic       sel_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_sync <= '0;
        else     sel_sync <= {sel_sync[0], sel_async};
    end

    assign sel_s = sel_sync[1];

    // Switching in the same cycle means the register loads the new (low) tap,
    // so an old tap that is just rising never reaches clk_out.
    always_comb begin
        sel_d = sel_q;
        if ((sel_s != sel_q) && !clk_out && !(sel_s ? tap1 : tap0))
            sel_d = sel_s;
    end

    assign clk_next = sel_d ? tap1 : tap0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            clk_out <= clk_next;
            tick    <= clk_next & ~clk_out;
        end
    end

endmodule

// File: rtl/clk_ctrl_gen.sv
// CPU clock and periodic interrupt generator. Define CLKGEN_STEP_EN to add
// the debounced single-step clock source.
module clk_ctrl_gen
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned FAST_TAP = FAST_TAP_DEF,
    parameter int unsigned SLOW_TAP = SLOW_TAP_DEF,
    parameter int unsigned INT_W    = INT_W_DEF,
    parameter int unsigned DB_TAP   = DB_TAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             speed_sel,
    input  logic             int_en,
    input  logic [INT_W-1:0] int_period,
    input  logic             int_ack,
    input  logic             step_mode,
    input  logic             step_btn,
    output logic [CNT_W-1:0] clkdiv,
    output logic             clk_cpu,
    output logic             cpu_tick,
    output logic             int_req,
    output logic             int_ovf
);

    logic [INT_W-1:0] tcnt;
    logic             run;
    logic             expire;
    int_state_t       state;
    int_state_t       state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) clkdiv <= '0;
        else     clkdiv <= clkdiv + CNT_W'(1);
    end

`ifdef CLKGEN_STEP_EN
    logic [1:0] btn_sync;
    logic       db_prev;
    logic       btn_db;
    logic       speed_next;
    logic       unused_speed_clk;
    logic       unused_speed_tick;
    logic       unused_step_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync <= '0;
            db_prev  <= 1'b0;
            btn_db   <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[0], step_btn};
            db_prev  <= clkdiv[DB_TAP];
            if (clkdiv[DB_TAP] && !db_prev)
                btn_db <= btn_sync[1];
        end
    end

    // The speed selector feeds its pre-register value forward so the step
    // selector adds no extra latency to the normal clock path.
    clk_tap_switch u_speed (
        .clk       (clk),
        .rst       (rst),
        .sel_async (speed_sel),
        .tap0      (clkdiv[FAST_TAP]),
        .tap1      (clkdiv[SLOW_TAP]),
        .clk_next  (speed_next),
        .clk_out   (unused_speed_clk),
        .tick      (unused_speed_tick)
    );

    clk_tap_switch u_step (
        .clk       (clk),
        .rst       (rst),
        .sel_async (step_mode),
        .tap0      (speed_next),
        .tap1      (btn_db),
        .clk_next  (unused_step_next),
        .clk_out   (clk_cpu),
        .tick      (cpu_tick)
    );
`else
    logic unused_clk_next;
    logic unused_step;

    assign unused_step = ^{step_mode, step_btn, (DB_TAP > 0)};

    clk_tap_switch u_speed (
        .clk       (clk),
        .rst       (rst),
        .sel_async (speed_sel),
        .tap0      (clkdiv[FAST_TAP]),
        .tap1      (clkdiv[SLOW_TAP]),
        .clk_next  (unused_clk_next),
        .clk_out   (clk_cpu),
        .tick      (cpu_tick)
    );
`endif

    assign run    = int_en && (int_period != '0);
    assign expire = run && (tcnt == int_period - INT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  tcnt <= '0;
        else if (!run || expire)  tcnt <= '0;
        else                      tcnt <= tcnt + INT_W'(1);
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (expire) state_d = PENDING;
            PENDING: begin
                if (expire && !int_ack) state_d = OVERRUN;
                else if (!expire && int_ack) state_d = IDLE;
            end
            OVERRUN: if (int_ack) state_d = expire ? PENDING : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            int_req <= 1'b0;
            int_ovf <= 1'b0;
        end else begin
            state   <= state_d;
            int_req <= (state_d != IDLE);
            int_ovf <= (state_d == OVERRUN);
        end
    end

endmodule

// File: tb/tb_clk_ctrl_gen.sv
// Directed bench for clk_ctrl_gen: divider, tap switching, interrupt timer and
// FSM, asynchronous reset; the step-button section is built with CLKGEN_STEP_EN.
module tb_clk_ctrl_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        speed_sel;
    logic        int_en;
    logic [31:0] int_period;
    logic        int_ack;
    logic        step_mode;
    logic        step_btn;
    logic [31:0] clkdiv;
    logic        clk_cpu;
    logic        cpu_tick;
    logic        int_req;
    logic        int_ovf;

    int unsigned n_cmp;
    int unsigned n_bad;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    clk_ctrl_gen #(
        .CNT_W    (32),
        .FAST_TAP (3),
        .SLOW_TAP (6),
        .INT_W    (32),
        .DB_TAP   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .speed_sel  (speed_sel),
        .int_en     (int_en),
        .int_period (int_period),
        .int_ack    (int_ack),
        .step_mode  (step_mode),
        .step_btn   (step_btn),
        .clkdiv     (clkdiv),
        .clk_cpu    (clk_cpu),
        .cpu_tick   (cpu_tick),
        .int_req    (int_req),
        .int_ovf    (int_ovf)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_v(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    initial begin
        int          found;
        int          hi_len;
        int          first_len;
        int          n_short;
        int          n64;
        int          n_pulses;
        int          bad_track;
        int          ticks;
        logic        prev_clk;
        logic [31:0] prevdiv;
        logic [31:0] cd;

        n_cmp = 0; n_bad = 0;
        rst = 1'b1; speed_sel = 1'b0; int_en = 1'b0; int_period = '0;
        int_ack = 1'b0; step_mode = 1'b0; step_btn = 1'b0;

        repeat (3) cyc();
        expect_v("rst_clkdiv", 0);   check_v(clkdiv);
        expect_v("rst_clk_cpu", 0);  check_v({31'b0, clk_cpu});
        expect_v("rst_cpu_tick", 0); check_v({31'b0, cpu_tick});
        expect_v("rst_int_req", 0);  check_v({31'b0, int_req});
        expect_v("rst_int_ovf", 0);  check_v({31'b0, int_ovf});

        // Fast tap: clk_cpu follows bit3 of the previous clkdiv value.
        rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            prevdiv = c - 1;
            expect_v("fast_clkdiv", c);
            expect_v("fast_clk_cpu", {31'b0, prevdiv[3]});
            expect_v("fast_tick", ((c % 16) == 9) ? 32'd1 : 32'd0);
            cyc();
            check_v(clkdiv);
            check_v({31'b0, clk_cpu});
            check_v({31'b0, cpu_tick});
        end

        found = 0;
        for (int i = 0; i < 32 && found == 0; i++) begin
            cyc();
            if (cpu_tick) found = 1;
        end
        expect_v("fast_tick_seen", 1); check_v(found);

        // Switch to the slow tap in the middle of a fast high phase.
        speed_sel = 1'b1;
        expect_v("switch_first_high", 8);
        expect_v("switch_short_pulses", 0);
        expect_v("switch_slow_pulses", 1);
        expect_v("switch_slow_track", 0);
        hi_len = 1; first_len = -1; n_short = 0; n64 = 0; n_pulses = 0;
        bad_track = 0; prev_clk = 1'b1;
        for (int i = 0; i < 500; i++) begin
            cyc();
            if (clk_cpu) hi_len++;
            if (prev_clk && !clk_cpu) begin
                n_pulses++;
                if (first_len < 0) first_len = hi_len;
                if (hi_len < 8) n_short++;
                if (hi_len == 64) n64++;
            end
            if (!prev_clk && clk_cpu) hi_len = 1;
            if (i >= 400) begin
                prevdiv = clkdiv - 32'd1;
                if (clk_cpu !== prevdiv[6]) bad_track++;
            end
            prev_clk = clk_cpu;
        end
        check_v(first_len);
        check_v(n_short);
        check_v((n64 >= 2) ? 32'd1 : 32'd0);
        check_v(bad_track);

        // Period 100 timer with ack handshake.
        int_en = 1'b1; int_period = 32'd100;
        expect_v("t100_before", 0); repeat (99) cyc(); check_v({31'b0, int_req});
        expect_v("t100_rise", 1);   cyc();             check_v({31'b0, int_req});
        expect_v("t100_ovf", 0);                       check_v({31'b0, int_ovf});
        repeat (5) cyc();
        int_ack = 1'b1;
        expect_v("t100_ack", 0); cyc(); check_v({31'b0, int_req});
        int_ack = 1'b0;
        repeat (44) cyc();
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        expect_v("idle_ack_ignored", 0); check_v({31'b0, int_req});
        expect_v("t100_second_before", 0); repeat (48) cyc(); check_v({31'b0, int_req});
        expect_v("t100_second", 1);        cyc();             check_v({31'b0, int_req});

        // Disabling keeps the pending request until acked; stopped timer stays quiet.
        int_en = 1'b0;
        expect_v("en_fall_hold", 1); repeat (2) cyc(); check_v({31'b0, int_req});
        int_ack = 1'b1;
        expect_v("en_fall_ack", 0); cyc(); check_v({31'b0, int_req});
        int_ack = 1'b0;
        expect_v("disabled_quiet", 0); repeat (120) cyc(); check_v({31'b0, int_req});

        // Period 10: overrun, coincident ack/expire in PENDING and OVERRUN.
        int_en = 1'b1; int_period = 32'd10;
        expect_v("t10_before", 0); repeat (9) cyc(); check_v({31'b0, int_req});
        expect_v("t10_req", 1);    cyc();            check_v({31'b0, int_req});
        expect_v("t10_no_ovf", 0);                   check_v({31'b0, int_ovf});
        expect_v("t10_pre_ovf", 0); repeat (9) cyc(); check_v({31'b0, int_ovf});
        expect_v("t10_ovf", 1);     cyc();            check_v({31'b0, int_ovf});
        expect_v("t10_ovf_req", 1);                   check_v({31'b0, int_req});
        repeat (5) cyc();
        expect_v("t10_held_req", 1); check_v({31'b0, int_req});
        expect_v("t10_held_ovf", 1); check_v({31'b0, int_ovf});
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        expect_v("ovf_ack_req", 0); check_v({31'b0, int_req});
        expect_v("ovf_ack_ovf", 0); check_v({31'b0, int_ovf});
        expect_v("t10_j30_req", 1); repeat (4) cyc(); check_v({31'b0, int_req});
        repeat (9) cyc();
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        expect_v("pend_coinc_req", 1); check_v({31'b0, int_req});
        expect_v("pend_coinc_ovf", 0); check_v({31'b0, int_ovf});
        expect_v("t10_j50_ovf", 1); repeat (10) cyc(); check_v({31'b0, int_ovf});
        repeat (9) cyc();
        int_ack = 1'b1; cyc();
        expect_v("ovr_coinc_req", 1); check_v({31'b0, int_req});
        expect_v("ovr_coinc_ovf", 0); check_v({31'b0, int_ovf});
        cyc(); int_ack = 1'b0;
        expect_v("t10_j61_req", 0); check_v({31'b0, int_req});

        // Asynchronous reset while clk_cpu is high.
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            cyc();
            if (clk_cpu) found = 1;
        end
        expect_v("arst_high_seen", 1); check_v(found);
        #2 rst = 1'b1;
        #1;
        expect_v("arst_clk_cpu", 0); check_v({31'b0, clk_cpu});
        expect_v("arst_clkdiv", 0);  check_v(clkdiv);
        expect_v("arst_int_req", 0); check_v({31'b0, int_req});
        expect_v("arst_int_ovf", 0); check_v({31'b0, int_ovf});

`ifdef CLKGEN_STEP_EN
        speed_sel = 1'b0; int_en = 1'b0;
        cyc();
        rst = 1'b0;
        step_mode = 1'b1;
        repeat (40) cyc();
        expect_v("step_idle_low", 0); check_v({31'b0, clk_cpu});

        found = 0;
        for (int i = 0; i < 16 && found == 0; i++) begin
            cyc();
            cd = clkdiv;
            if (cd[2:0] == 3'b100) found = 1;
        end
        expect_v("step_align", 1); check_v(found);
        step_btn = 1'b1; repeat (3) cyc(); step_btn = 1'b0;
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (cpu_tick) ticks++;
        end
        expect_v("step_glitch_ticks", 0); check_v(ticks);

        step_btn = 1'b1;
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (cpu_tick) ticks++;
        end
        expect_v("step_press_ticks", 1); check_v(ticks);
        expect_v("step_press_high", 1);  check_v({31'b0, clk_cpu});
        #2 rst = 1'b1;
        #1;
        expect_v("step_arst_clk_cpu", 0); check_v({31'b0, clk_cpu});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_ctrl_gen.md
Name: clk_ctrl_gen

Overview:
Parametrised CPU clock and timer-interrupt generator for the single-cycle/multi-cycle CPU top.
- Keeps a free-running divide counter.
- Derives a glitch-free CPU clock from one of two counter taps.
- Emits a one-cycle tick on each CPU clock rising edge.
- Raises a periodic interrupt request, held by an ack handshake with overrun detection, for the CPU interrupt logic.

Parameters:
CNT_W, 32, width of free-running counter clkdiv
FAST_TAP, 3, counter bit used as CPU clock when speed_sel=0
SLOW_TAP, 24, counter bit used as CPU clock when speed_sel=1
INT_W, 32, width of interrupt period counter
DB_TAP, 16, counter bit whose rising edge samples step button (step feature only)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
speed_sel  in  1  0=fast tap, 1=slow tap; asynchronous switch input
int_en  in  1  interrupt timer enable
int_period  in  INT_W  timer period in clk cycles; 0 = timer stopped
int_ack  in  1  CPU acknowledges pending interrupt
step_mode  in  1  single-step select (step feature only)
step_btn  in  1  raw push-button (step feature only)
clkdiv  out  CNT_W  free-running counter
clk_cpu  out  1  registered CPU clock
cpu_tick  out  1  one-cycle pulse, clk_cpu 0->1
int_req  out  1  interrupt request, level, held until ack
int_ovf  out  1  sticky overrun: period expired while int_req pending

Behaviour:
- Reset: all outputs 0; internal selection register = fast; timer counter 0; FSM IDLE.
- clkdiv: +1 every clk; wraps from all-ones to 0.
- speed_sel: 2-flop synchronised.
- Active selection changes only in a cycle where clk_cpu=0 and the new tap bit=0. Until then the old tap is kept. No runt high pulse.
- clk_cpu: registered copy of the active tap. One clk latency behind clkdiv.
- cpu_tick: 1 exactly in the cycle clk_cpu goes 0->1.
- Timer counter tcnt:
  - Held at 0 while int_en=0 or int_period=0.
  - Otherwise increments each clk.
  - At tcnt==int_period-1: tcnt<=0 and expire=1 for one cycle.
  - If int_period is lowered below tcnt: tcnt wraps naturally. No special handling.
- Interrupt FSM:
  - IDLE: expire -> PENDING.
  - PENDING: int_ack -> IDLE; expire without ack -> OVERRUN; expire with ack -> stay PENDING (new request).
  - OVERRUN: int_ack -> IDLE, unless expire in the same cycle -> PENDING.
- int_req = (state != IDLE). int_ovf = (state == OVERRUN). Both are registered.
- int_ack while IDLE: ignored.
- int_en falling: tcnt cleared; a pending request remains until acked.
- Reset mid-operation clears everything immediately. clk_cpu is forced low (asynchronous).

Optional Feature:
CLKGEN_STEP_EN
- Defined:
  - step_btn is 2-flop synchronised, then sampled on each rising edge of clkdiv[DB_TAP] (debounce).
  - While synchronised step_mode=1, clk_cpu = debounced level; cpu_tick pulses once per press.
  - Entering or leaving step mode obeys the same low-low switch rule as speed_sel.
- Undefined: step_mode and step_btn are ignored; no debounce logic is generated.

Decomposition:
- Package clk_ctrl_pkg: FSM state enum (IDLE, PENDING, OVERRUN) and default tap/width constants.
- One natural sub-module, clk_tap_switch: synchroniser plus glitch-free tap-selection register producing clk_cpu and cpu_tick. Reused for step-mode selection.

Test Plan:
- Reset released, speed_sel=0: clkdiv counts 0,1,2…; clk_cpu first rises at clkdiv=9 (bit3 set at 8, +1 latency); cpu_tick pulses once per 16 clk.
- speed_sel 0->1 while bit3=1: clk_cpu completes its high phase. The switch occurs only when clk_cpu=0 and bit24=0. No high pulse shorter than 8 clk.
- int_en=1, int_period=100: int_req rises at the 100th clk after enable; int_ack 5 cycles later -> int_req=0; the next request arrives 100 clk after the previous one.
- int_period=10, no ack for 25 clk: int_req=1, then int_ovf=1 after the second expiry; int_ack -> both 0 next cycle.
- int_ack coincident with expire in PENDING: int_req stays 1 and int_ovf stays 0. In OVERRUN the same case gives int_ovf=0 and int_req=1.
- CLKGEN_STEP_EN, DB_TAP=2, step_mode=1: a 3-clk button glitch produces no cpu_tick; a held press produces exactly one cpu_tick. rst asserted mid-press forces clk_cpu=0 immediately.
